// File: rtl/noc_inject_arbiter_pkg.sv
// Shared constants for the NoC injection arbiter: data width default, FSM encodings, requester limit.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

package noc_inject_arbiter_pkg;
  localparam int NOC_DATA_W          = `Noc_Data_Width;
  localparam int NOC_INJ_ARB_MAX_REQ = 8;
  localparam logic [0:0] ARB_IDLE    = 1'b0;
  localparam logic [0:0] ARB_LOCKED  = 1'b1;
endpackage

// File: rtl/noc_inject_arbiter_if.sv
// Flit handshake bundle (valid/ready plus header/tail markers), N lanes wide.
interface noc_inject_arbiter_if import noc_inject_arbiter_pkg::*; #(
  parameter int N      = 1,
  parameter int DATA_W = NOC_DATA_W
);
  logic [N-1:0]             valid;
  logic [N-1:0]             ready;
  logic [N-1:0][DATA_W-1:0] flit;
  logic [N-1:0]             is_header;
  logic [N-1:0]             is_tail;

  modport master (output valid, flit, is_header, is_tail, input ready);
  modport slave  (input valid, flit, is_header, is_tail, output ready);
endinterface

// File: rtl/noc_inject_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit of req scanning rr_ptr, rr_ptr+1, ... mod N.
module noc_rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
)(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDX_W:0] sum;

  // rot[k] is the request at scan position k
  assign dbl = {req, req};
  assign rot = N'(dbl >> rr_ptr);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        idx   = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N)) : IDX_W'(sum);
      end
    end
  end
endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-granular round-robin arbiter for the router local injection port, 1-flit output register.
// NOC_INJ_ARB_STATS_EN adds per-source completed-packet counters (pkt_cnt).
module noc_inject_arbiter import noc_inject_arbiter_pkg::*; #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = NOC_DATA_W,
  localparam int IDX_W   = $clog2(NUM_REQ)
)(
  input  logic               noc_clk,
  input  logic               noc_rst,
  noc_inject_arbiter_if.slave  req,
  noc_inject_arbiter_if.master snd,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic               proto_err
`ifdef NOC_INJ_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0] pkt_cnt
`endif
);
  if (NUM_REQ < 2 || NUM_REQ > NOC_INJ_ARB_MAX_REQ) begin : g_bad_num_req
    $error("noc_inject_arbiter: NUM_REQ out of range");
  end

  logic [0:0]         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic               hdr_seen;
  logic               locked, free, xfer;
  logic               cand_found, vld_found;
  logic [IDX_W-1:0]   cand_idx, vld_idx;
  logic [NUM_REQ-1:0] cand;
  logic [DATA_W-1:0]  g_flit;
  logic               g_hdr, g_tail;

  assign cand   = req.valid & req.is_header;
  assign locked = (state == ARB_LOCKED);
  assign free   = !snd.valid[0] || snd.ready[0];
  assign g_flit = req.flit[grant_idx];
  assign g_hdr  = req.is_header[grant_idx];
  assign g_tail = req.is_tail[grant_idx];
  assign xfer   = locked && req.valid[grant_idx] && free;

  noc_rr_pick #(.N(NUM_REQ)) u_pick_hdr (
    .req(cand), .rr_ptr(rr_ptr), .found(cand_found), .idx(cand_idx)
  );
  // Same scan over all valid sources, to spot a stray body flit at top priority
  noc_rr_pick #(.N(NUM_REQ)) u_pick_vld (
    .req(req.valid), .rr_ptr(rr_ptr), .found(vld_found), .idx(vld_idx)
  );

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign req.ready[i] = locked && (grant_idx == IDX_W'(i)) && free;
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state         <= ARB_IDLE;
      rr_ptr        <= '0;
      grant_idx     <= '0;
      busy          <= 1'b0;
      proto_err     <= 1'b0;
      hdr_seen      <= 1'b0;
      snd.valid     <= '0;
      snd.flit      <= '0;
      snd.is_header <= '0;
      snd.is_tail   <= '0;
    end else begin
      if (xfer) begin
        snd.valid[0]     <= 1'b1;
        snd.flit[0]      <= g_flit;
        snd.is_header[0] <= g_hdr;
        snd.is_tail[0]   <= g_tail;
      end else if (snd.ready[0]) begin
        snd.valid[0] <= 1'b0;
      end

      case (state)
        ARB_IDLE: begin
          if (vld_found && !req.is_header[vld_idx]) proto_err <= 1'b1;
          if (cand_found) begin
            grant_idx <= cand_idx;
            busy      <= 1'b1;
            hdr_seen  <= 1'b0;
            state     <= ARB_LOCKED;
          end
        end
        default: begin
          if (xfer) begin
            hdr_seen <= 1'b1;
            // A second header inside the lock means the source dropped its tail
            if (g_hdr && hdr_seen) proto_err <= 1'b1;
            if (g_tail) begin
              busy   <= 1'b0;
              rr_ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
              state  <= ARB_IDLE;
            end
          end
        end
      endcase
    end
  end

`ifdef NOC_INJ_ARB_STATS_EN
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      pkt_cnt <= '0;
    end else if (xfer && g_tail) begin
      pkt_cnt[grant_idx] <= pkt_cnt[grant_idx] + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Scoreboard bench for noc_inject_arbiter: per-source flit queues drive requests, a monitor checks sender output order.
module tb_noc_inject_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] f;
    logic          h;
    logic          t;
  } fl_t;

  logic       noc_clk = 1'b0;
  logic       noc_rst = 1'b1;
  logic [1:0] grant_idx;
  logic       busy, proto_err;
`ifdef NOC_INJ_ARB_STATS_EN
  logic [NR-1:0][15:0] pkt_cnt;
`endif

  noc_inject_arbiter_if #(.N(NR), .DATA_W(DW)) req_if();
  noc_inject_arbiter_if #(.N(1),  .DATA_W(DW)) snd_if();

  noc_inject_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .noc_clk   (noc_clk),
    .noc_rst   (noc_rst),
    .req       (req_if),
    .snd       (snd_if),
    .grant_idx (grant_idx),
    .busy      (busy),
    .proto_err (proto_err)
`ifdef NOC_INJ_ARB_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt)
`endif
  );

  always #5 noc_clk = ~noc_clk;

  int  vectors = 0;
  int  errors  = 0;
  fl_t src_q[NR][$];
  fl_t exp_q[$];

  function automatic logic [DW-1:0] mk(input int s, input int p, input int k);
    return {4'(s), 4'(p), 8'(k)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
    end
  endtask

  task automatic send_pkt(input int s, input int p, input int n, input bit to_src, input bit to_exp);
    fl_t e;
    for (int k = 0; k < n; k++) begin
      e.f = mk(s, p, k);
      e.h = (k == 0);
      e.t = (k == n-1);
      if (to_src) src_q[s].push_back(e);
      if (to_exp) exp_q.push_back(e);
    end
  endtask

  // Asserts reset, checks reset values immediately, flushes queues, releases on a negedge
  task automatic do_reset();
    noc_rst = 1'b1;
    #1;
    chk("rst_valid",  32'(snd_if.valid[0]), 0);
    chk("rst_flit",   32'({snd_if.flit[0], snd_if.is_header[0], snd_if.is_tail[0]}), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_perr",   32'(proto_err), 0);
    chk("rst_ready",  32'(req_if.ready), 0);
    chk("rst_grant",  32'(grant_idx), 0);
`ifdef NOC_INJ_ARB_STATS_EN
    for (int i = 0; i < NR; i++) chk("rst_pkt_cnt", 32'(pkt_cnt[i]), 0);
`endif
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) @(posedge noc_clk);
    @(negedge noc_clk);
    noc_rst = 1'b0;
  endtask

  task automatic wait_hdr(input string name);
    int n = 0;
    do begin
      @(negedge noc_clk);
      n++;
    end while (!(snd_if.valid[0] && snd_if.is_header[0]) && n < 30);
    chk(name, 32'(snd_if.valid[0] & snd_if.is_header[0]), 1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    do begin
      @(negedge noc_clk);
      n++;
    end while ((exp_q.size() != 0 || busy || snd_if.valid[0]) && n < 300);
    chk(name, 32'(exp_q.size()), 0);
  endtask

  // Source driver: drop a flit after it was accepted, present the next one
  initial begin : drv
    logic [NR-1:0] go;
    req_if.valid     = '0;
    req_if.flit      = '0;
    req_if.is_header = '0;
    req_if.is_tail   = '0;
    forever begin
      @(negedge noc_clk);
      go = req_if.valid & req_if.ready;
      @(posedge noc_clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (go[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          req_if.valid[i]     = 1'b1;
          req_if.flit[i]      = src_q[i][0].f;
          req_if.is_header[i] = src_q[i][0].h;
          req_if.is_tail[i]   = src_q[i][0].t;
        end else begin
          req_if.valid[i]     = 1'b0;
          req_if.flit[i]      = '0;
          req_if.is_header[i] = 1'b0;
          req_if.is_tail[i]   = 1'b0;
        end
      end
    end
  end

  // Monitor: every accepted output flit must be the next expected one
  initial begin : mon
    fl_t a, e;
    forever begin
      @(negedge noc_clk);
      if (!noc_rst && snd_if.valid[0] && snd_if.ready[0]) begin
        a = {snd_if.flit[0], snd_if.is_header[0], snd_if.is_tail[0]};
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got flit %h h=%0b t=%0b, required no output", a.f, a.h, a.t);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL out_flit: got %h h=%0b t=%0b, required %h h=%0b t=%0b", a.f, a.h, a.t, e.f, e.h, e.t);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    fl_t bad;
    snd_if.ready = 1'b1;
    @(posedge noc_clk);
    #2;
    do_reset();

    // Body flit offered while idle by the top-priority source
    bad = {mk(0, 15, 1), 1'b0, 1'b0};
    src_q[0].push_back(bad);
    repeat (4) @(negedge noc_clk);
    chk("t5_proto_err", 32'(proto_err), 1);
    chk("t5_ready",     32'(req_if.ready), 0);
    chk("t5_valid",     32'(snd_if.valid[0]), 0);
    chk("t5_busy",      32'(busy), 0);
    @(posedge noc_clk);
    #2;
    do_reset();

    // Source 2 alone: H,D,T back to back
    send_pkt(2, 1, 3, 1, 1);
    @(negedge noc_clk);
    chk("t1_busy0",  32'(busy), 0);
    chk("t1_rdy0",   32'(req_if.ready), 0);
    @(negedge noc_clk);
    chk("t1_busy1",  32'(busy), 1);
    chk("t1_grant",  32'(grant_idx), 2);
    chk("t1_rdy",    32'(req_if.ready), 32'h4);
    for (int k = 0; k < 3; k++) begin
      @(negedge noc_clk);
      chk("t1_b2b", 32'(snd_if.valid[0]), 1);
    end
    wait_drain("t1_drain");
    chk("t1_idle", 32'(busy), 0);
    // rr_ptr now 3: source 3 beats source 0
    send_pkt(0, 9, 1, 1, 0);
    send_pkt(3, 9, 1, 1, 1);
    send_pkt(0, 9, 1, 0, 1);
    wait_drain("t1_rr3");
    @(posedge noc_clk);
    #2;
    do_reset();

    // All four sources, two packets each
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NR; s++) send_pkt(s, 2 + r, 3, 1, 1);
    wait_drain("t2_drain");
`ifdef NOC_INJ_ARB_STATS_EN
    for (int s = 0; s < NR; s++) chk("t2_pkt_cnt", 32'(pkt_cnt[s]), 2);
`endif

    // Backpressure for 5 cycles with D on the output
    send_pkt(1, 3, 3, 1, 1);
    wait_hdr("t3_hdr");
    @(posedge noc_clk);
    #2;
    snd_if.ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge noc_clk);
      chk("t3_hold", 32'({snd_if.valid[0], snd_if.flit[0], snd_if.is_tail[0]}), 32'({1'b1, mk(1, 3, 1), 1'b0}));
      chk("t3_rdy",  32'(req_if.ready), 0);
    end
    @(posedge noc_clk);
    #2;
    snd_if.ready = 1'b1;
    wait_drain("t3_drain");

    // Single-flit packet from source 1, then source 1 again vs source 0 (rr_ptr=2)
    send_pkt(1, 4, 1, 1, 1);
    send_pkt(1, 5, 2, 1, 0);
    @(negedge noc_clk);
    @(negedge noc_clk);
    chk("t4_grant1", 32'(grant_idx), 1);
    send_pkt(0, 4, 2, 1, 1);
    send_pkt(1, 5, 2, 0, 1);
    @(negedge noc_clk);
    chk("t4_bubble", 32'(busy), 0);
    @(negedge noc_clk);
    chk("t4_grant0", 32'({busy, grant_idx}), 32'h4);
    wait_drain("t4_drain");

    // Reset during the data flit; afterwards arbitration restarts at rr_ptr=0
    send_pkt(2, 6, 3, 1, 1);
    wait_hdr("t6_hdr");
    @(posedge noc_clk);
    #2;
    do_reset();
    send_pkt(1, 7, 2, 1, 1);
    send_pkt(3, 7, 2, 1, 1);
    @(negedge noc_clk);
    @(negedge noc_clk);
    chk("t6_grant", 32'({busy, grant_idx}), 32'h5);
    wait_drain("t6_drain");
`ifdef NOC_INJ_ARB_STATS_EN
    chk("t6_pkt_cnt1", 32'(pkt_cnt[1]), 1);
    chk("t6_pkt_cnt2", 32'(pkt_cnt[2]), 0);
    chk("t6_pkt_cnt3", 32'(pkt_cnt[3]), 1);
`endif
    chk("final_perr", 32'(proto_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
